minimig_bankmap_prog: RTL and testbench
=======================================

# minimig_bankmap_prog

Programmable, registered successor to the fixed chip/slow/ROM bank decoder. It sits between the Amiga address decoder, which produces one-hot region selects, and the SDRAM/bank arbiter. A run-time table maps each region-select line to one output bank. The host controller rewrites the table through a shadow copy that is committed only at a safe point between accesses, so a remap never corrupts an in-flight cycle.

## Interface
Parameters:
- NSEL, default 12: number of region-select inputs (chip0..3, slow0..2, kick, kickext, kick1mb, cart, drivesounds).
- NBANK, default 8: number of output bank lines; BW = $clog2(NBANK).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sel  in  NSEL  region selects for the current access; normally one-hot.
- sel_valid  in  1  access strobe; sel is sampled only when high.
- bank  out  NBANK  registered bank select.
- bank_valid  out  1  registered copy of sel_valid.
- cfg_we  in  1  shadow-table write strobe.
- cfg_addr  in  $clog2(NSEL)  table entry index.
- cfg_data  in  BW+1  entry value {en, idx[BW-1:0]}.
- cfg_commit  in  1  request to copy the shadow table into the active table.
- cfg_busy  out  1  commit pending.
- cfg_done  out  1  one-cycle pulse when a commit has been applied.
- multi_hit  out  1  sticky flag: an access had two or more enabled selects.

## Operation
- Two tables, each NSEL entries of {en, idx}: shadow and active.
- Reset value of both tables, entry i: en=1, idx = i mod NBANK.
- Mapping:
  - hit_i = sel_valid & sel[i] & active.en[i].
  - next_bank = bitwise OR over i of (hit_i ? (1 << active.idx[i]) : 0).
  - An idx of NBANK or more contributes nothing. This is only possible when NBANK is not a power of 2.
- Zero hits gives next_bank = 0 with bank_valid still high. This is a legal unmapped access.
- multi_hit is set when two or more hit_i are high in the same cycle. It clears only on reset or on a cfg_done cycle.
- Shadow writes: on cfg_we with cfg_busy low and cfg_addr < NSEL, shadow[cfg_addr] <= cfg_data. Writes with cfg_busy high, or with cfg_addr >= NSEL, are ignored.
- Commit state machine, two states:
  - IDLE to PEND on cfg_commit.
  - PEND to IDLE at the first rising edge where sel_valid is 0. On that edge active <= shadow and cfg_done <= 1.
  - cfg_commit while in PEND is ignored.
  - cfg_commit coinciding with cfg_we: the write lands first and is included in the commit.
- cfg_busy = (state == PEND).
- A commit requested in a cycle with sel_valid low still takes one cycle to reach PEND. It is applied at the next sel_valid-low edge or later.
- Starvation: if sel_valid stays high, the commit waits indefinitely. There is no timeout.

## Timing
- Reset values: bank=0, bank_valid=0, cfg_busy=0, cfg_done=0, multi_hit=0, state=IDLE.
- Access latency is 1 cycle: sel and sel_valid sampled at edge N appear on bank and bank_valid after edge N. When sel_valid is low, bank is 0 on the next cycle.
- An access at the edge where a commit is applied cannot occur, because that edge requires sel_valid=0. The first access after cfg_done uses the new table.
- cfg_done is high for exactly one cycle, in the cycle after the copy edge.
- Reset asserted mid-commit restores the reset tables and IDLE immediately, without waiting for a clock edge.

## Test plan
- Reset with default parameters, then sel=12'h004 with sel_valid=1 → next cycle bank=8'h04, bank_valid=1, multi_hit=0.
- Write entry 2 = {1,3'd6}, commit with sel_valid=0 → cfg_busy high 1 cycle, then cfg_done pulses; the next sel=12'h004 gives bank=8'h40.
- Write entry 5 = {0,3'd0}, commit, then sel=12'h020 → bank=8'h00 with bank_valid=1.
- Commit while sel_valid is held high for 10 cycles → cfg_busy stays 1 and the old mapping is used throughout. A cfg_we to entry 0 during that window is ignored. cfg_done appears in the cycle after sel_valid drops.
- sel=12'h003 under the default table → bank=8'h03 and multi_hit=1, still 1 after 5 idle cycles, cleared on the next cfg_done.
- Assert reset_n=0 while cfg_busy=1 → outputs 0 immediately. After release, sel=12'h004 gives bank=8'h04, confirming the identity table is back.

Source files
------------

// File: rtl/minimig_bankmap_prog.sv
// Programmable region-select to bank mapper with a shadow table that is
// committed only between accesses, so a remap never splits an in-flight cycle.
module minimig_bankmap_prog #(
   parameter  int NSEL  = 12,
   parameter  int NBANK = 8,
   localparam int BW    = $clog2(NBANK),
   localparam int AW    = $clog2(NSEL)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NSEL-1:0]  sel,
   input  logic             sel_valid,
   output logic [NBANK-1:0] bank,
   output logic             bank_valid,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [BW:0]      cfg_data,
   input  logic             cfg_commit,
   output logic             cfg_busy,
   output logic             cfg_done,
   output logic             multi_hit
);

   // state     | meaning
   // ST_IDLE   | active table in use, shadow writable
   // ST_PEND   | commit requested, waiting for an edge with sel_valid low
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PEND = 1'b1;

   localparam logic [NBANK-1:0] BANK_ONE = NBANK'(1);

   logic [0:0]             state_q, state_d;
   logic [NSEL-1:0]        sh_en_q, sh_en_d;
   logic [NSEL-1:0][BW-1:0] sh_idx_q, sh_idx_d;
   logic [NSEL-1:0]        act_en_q, act_en_d;
   logic [NSEL-1:0][BW-1:0] act_idx_q, act_idx_d;
   logic [NBANK-1:0]       bank_q, bank_d;
   logic                   bank_valid_q, bank_valid_d;
   logic                   cfg_done_q, cfg_done_d;
   logic                   multi_hit_q, multi_hit_d;

   logic [NSEL-1:0]        hit;
   logic                   multi_now;
   logic                   apply;
   logic                   write_ok;

   always_comb begin
      hit    = '0;
      bank_d = '0;
      for (int i = 0; i < NSEL; i++) begin
         hit[i] = sel_valid & sel[i] & act_en_q[i];
         // An out-of-range idx shifts the bit off the top and maps nowhere.
         if (hit[i]) bank_d = bank_d | (BANK_ONE << act_idx_q[i]);
      end
      multi_now    = (hit & (hit - NSEL'(1))) != '0;
      bank_valid_d = sel_valid;

      apply    = (state_q == ST_PEND) & ~sel_valid;
      write_ok = cfg_we & (state_q == ST_IDLE) &
                 ({1'b0, cfg_addr} < (AW+1)'(NSEL));

      state_d = state_q;
      case (state_q)
         ST_IDLE: if (cfg_commit) state_d = ST_PEND;
         ST_PEND: if (!sel_valid) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      sh_en_d  = sh_en_q;
      sh_idx_d = sh_idx_q;
      for (int i = 0; i < NSEL; i++) begin
         if (write_ok && (cfg_addr == AW'(i))) begin
            sh_en_d[i]  = cfg_data[BW];
            sh_idx_d[i] = cfg_data[BW-1:0];
         end
      end

      act_en_d    = apply ? sh_en_q  : act_en_q;
      act_idx_d   = apply ? sh_idx_q : act_idx_q;
      cfg_done_d  = apply;
      multi_hit_d = apply ? 1'b0 : (multi_hit_q | multi_now);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         sh_en_q      <= '1;
         act_en_q     <= '1;
         for (int i = 0; i < NSEL; i++) begin
            sh_idx_q[i]  <= BW'(i % NBANK);
            act_idx_q[i] <= BW'(i % NBANK);
         end
         bank_q       <= '0;
         bank_valid_q <= 1'b0;
         cfg_done_q   <= 1'b0;
         multi_hit_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sh_en_q      <= sh_en_d;
         sh_idx_q     <= sh_idx_d;
         act_en_q     <= act_en_d;
         act_idx_q    <= act_idx_d;
         bank_q       <= bank_d;
         bank_valid_q <= bank_valid_d;
         cfg_done_q   <= cfg_done_d;
         multi_hit_q  <= multi_hit_d;
      end
   end

   assign bank       = bank_q;
   assign bank_valid = bank_valid_q;
   assign cfg_busy   = (state_q == ST_PEND);
   assign cfg_done   = cfg_done_q;
   assign multi_hit  = multi_hit_q;

endmodule

// File: tb/tb_minimig_bankmap_prog.sv
// Bench for minimig_bankmap_prog: directed vector table, hand-written commit
// corner cases, then random traffic against a table-level reference model.
module tb_minimig_bankmap_prog;

   localparam int NSEL  = 12;
   localparam int NBANK = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [11:0] sel;
   logic        sel_valid;
   logic [7:0]  bank;
   logic        bank_valid;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [3:0]  cfg_data;
   logic        cfg_commit;
   logic        cfg_busy;
   logic        cfg_done;
   logic        multi_hit;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   int sh_en[NSEL], sh_idx[NSEL], ac_en[NSEL], ac_idx[NSEL];
   int m_pend, m_bank, m_bv, m_done, m_mh;

   typedef struct {
      logic [11:0] sel;
      logic        sv, we;
      logic [3:0]  addr, data;
      logic        commit;
      logic [7:0]  bank;
      logic        bv, busy, done, mh, mh_chk;
   } vec_t;

   vec_t vecs[$];

   minimig_bankmap_prog #(.NSEL(NSEL), .NBANK(NBANK)) dut (
      .clk(clk), .reset_n(reset_n), .sel(sel), .sel_valid(sel_valid),
      .bank(bank), .bank_valid(bank_valid), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done), .multi_hit(multi_hit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NSEL; i++) begin
         sh_en[i] = 1; ac_en[i] = 1;
         sh_idx[i] = i % NBANK; ac_idx[i] = i % NBANK;
      end
      m_pend = 0; m_bank = 0; m_bv = 0; m_done = 0; m_mh = 0;
   endfunction

   // One clock edge of the table-level behaviour, using pre-edge inputs.
   function automatic void model_step();
      int hits, b, apply;
      if (!reset_n) begin
         model_reset();
         return;
      end
      hits = 0; b = 0;
      for (int i = 0; i < NSEL; i++)
         if (sel_valid && sel[i] && ac_en[i] != 0) begin
            hits++;
            if (ac_idx[i] < NBANK) b = b | (1 << ac_idx[i]);
         end
      m_bank = b;
      m_bv   = sel_valid;
      apply  = (m_pend != 0 && !sel_valid) ? 1 : 0;
      m_done = apply;
      m_mh   = apply ? 0 : ((m_mh != 0 || hits >= 2) ? 1 : 0);
      if (apply)
         for (int i = 0; i < NSEL; i++) begin
            ac_en[i] = sh_en[i]; ac_idx[i] = sh_idx[i];
         end
      if (cfg_we && m_pend == 0 && cfg_addr < NSEL) begin
         sh_en[cfg_addr]  = cfg_data[3];
         sh_idx[cfg_addr] = cfg_data[2:0];
      end
      if (m_pend != 0) m_pend = sel_valid ? 1 : 0;
      else             m_pend = cfg_commit ? 1 : 0;
   endfunction

   task automatic check_model(input string tag);
      chk({tag, ".bank"},       bank,       m_bank);
      chk({tag, ".bank_valid"}, bank_valid, m_bv);
      chk({tag, ".busy"},       cfg_busy,   m_pend);
      chk({tag, ".done"},       cfg_done,   m_done);
      chk({tag, ".multi_hit"},  multi_hit,  m_mh);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive(input logic [11:0] s, input logic sv, input logic we,
                        input logic [3:0] a, input logic [3:0] d, input logic c);
      sel = s; sel_valid = sv; cfg_we = we; cfg_addr = a; cfg_data = d; cfg_commit = c;
   endtask

   initial begin
      reset_n = 1'b0;
      drive(12'h000, 0, 0, 4'h0, 4'h0, 0);
      model_reset();
      #1;
      chk("rst.bank", bank, 0);
      chk("rst.bank_valid", bank_valid, 0);
      chk("rst.busy", cfg_busy, 0);
      chk("rst.done", cfg_done, 0);
      chk("rst.multi_hit", multi_hit, 0);
      tick(); tick();
      reset_n = 1'b1;

      // sel, sv, we, addr, data, commit | bank, bv, busy, done, mh, mh_chk
      vecs.push_back('{12'h004, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{12'h000, 1'b0, 1'b1, 4'h2, 4'hE, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{12'h000, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{12'h004, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{12'h000, 1'b0, 1'b1, 4'h5, 4'h0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{12'h000, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{12'h020, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{12'h003, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
      for (int k = 0; k < 5; k++)
         vecs.push_back('{12'h000, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{12'h000, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{12'h000, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{12'h000, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

      foreach (vecs[k]) begin
         drive(vecs[k].sel, vecs[k].sv, vecs[k].we, vecs[k].addr, vecs[k].data, vecs[k].commit);
         tick();
         chk($sformatf("vec%0d.bank", k), bank, vecs[k].bank);
         chk($sformatf("vec%0d.bank_valid", k), bank_valid, vecs[k].bv);
         chk($sformatf("vec%0d.busy", k), cfg_busy, vecs[k].busy);
         chk($sformatf("vec%0d.done", k), cfg_done, vecs[k].done);
         if (vecs[k].mh_chk) chk($sformatf("vec%0d.multi_hit", k), multi_hit, vecs[k].mh);
      end

      // Starved commit: sel_valid held high for 10 cycles, write during window ignored.
      drive(12'h000, 0, 1, 4'h1, 4'hF, 0);
      tick();
      for (int k = 0; k < 10; k++) begin
         drive(12'h002, 1, (k == 3), 4'h0, 4'hD, (k == 0));
         tick();
         chk($sformatf("starve%0d.busy", k), cfg_busy, 1);
         chk($sformatf("starve%0d.bank", k), bank, 8'h02);
         chk($sformatf("starve%0d.done", k), cfg_done, 0);
      end
      drive(12'h000, 0, 0, 4'h0, 4'h0, 0);
      tick();
      chk("starve.done", cfg_done, 1);
      chk("starve.busy_clr", cfg_busy, 0);
      drive(12'h002, 1, 0, 4'h0, 4'h0, 0);
      tick();
      chk("starve.newmap", bank, 8'h80);
      chk("starve.done_pulse", cfg_done, 0);
      drive(12'h001, 1, 0, 4'h0, 4'h0, 0);
      tick();
      chk("starve.ignored_we", bank, 8'h01);

      // Reset asserted while a commit is pending.
      drive(12'h004, 1, 0, 4'h0, 4'h0, 1);
      tick();
      chk("rstmid.busy_pre", cfg_busy, 1);
      chk("rstmid.bank_pre", bank, 8'h40);
      drive(12'h004, 1, 0, 4'h0, 4'h0, 0);
      tick();
      #2 reset_n = 1'b0;
      #1;
      chk("rstmid.bank", bank, 0);
      chk("rstmid.bank_valid", bank_valid, 0);
      chk("rstmid.busy", cfg_busy, 0);
      chk("rstmid.done", cfg_done, 0);
      chk("rstmid.multi_hit", multi_hit, 0);
      drive(12'h000, 0, 0, 4'h0, 4'h0, 0);
      tick();
      reset_n = 1'b1;
      drive(12'h004, 1, 0, 4'h0, 4'h0, 0);
      tick();
      chk("rstmid.identity", bank, 8'h04);
      check_model("rstmid");

      // Random traffic against the reference model.
      for (int k = 0; k < 3000; k++) begin
         int r;
         r = $urandom_range(0, 3);
         case (r)
            0:       sel = 12'h000;
            3:       sel = 12'($urandom);
            default: sel = 12'(1) << $urandom_range(0, 11);
         endcase
         sel_valid  = ($urandom_range(0, 9) < 7);
         cfg_we     = ($urandom_range(0, 4) == 0);
         cfg_addr   = 4'($urandom_range(0, 15));
         cfg_data   = 4'($urandom);
         cfg_commit = ($urandom_range(0, 9) == 0);
         tick();
         check_model($sformatf("rnd%0d", k));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
